// File: rtl/gerador_colunas.sv
// rtl/gerador_colunas.sv - scrolling-text column generator for a 5x7 LED matrix
//
// Holds a MSG_LEN-symbol message and renders it through a built-in 5x7 font.
// Each symbol becomes five glyph columns followed by one blank spacer column.
// A 5-column window scrolls across the resulting stream and wraps at its end.
//
// Ports:
//   clock                 system clock; all state changes on the rising edge
//   reset_n               asynchronous active-low reset
//   carregar              one-cycle pulse that starts loading a new message
//   simb_valid/simb_ready symbol handshake, active only while loading
//   simb_code[4:0]        0-9 digits, 10-15 A-F, 16 space, 17-31 blank
//   habilita              1 = scroll advances, 0 = window frozen
//   ocupado               high while a message is being loaded
//   coluna1..coluna5      registered column patterns, bit0 = top row
//
// Build option: INVERTE_LINHAS_EN makes the columns active-low (blank = 7'h7F).
module gerador_colunas #(
    parameter int MSG_LEN     = 8,
    parameter int DIV_ROLAGEM = 12500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       carregar,
    input  logic       simb_valid,
    output logic       simb_ready,
    input  logic [4:0] simb_code,
    input  logic       habilita,
    output logic       ocupado,
    output logic [6:0] coluna1,
    output logic [6:0] coluna2,
    output logic [6:0] coluna3,
    output logic [6:0] coluna4,
    output logic [6:0] coluna5
);

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int PRE_W = $clog2(DIV_ROLAGEM);
    localparam logic [IDX_W-1:0] ULTIMO_IDX = IDX_W'(MSG_LEN - 1);
    localparam logic [PRE_W-1:0] PRE_FIM    = PRE_W'(DIV_ROLAGEM - 1);

`ifdef INVERTE_LINHAS_EN
    localparam logic [6:0] BLANK = 7'h7F;
`else
    localparam logic [6:0] BLANK = 7'h00;
`endif

    typedef enum logic [1:0] {VAZIO, CARGA, EXIBE} estado_t;

    estado_t          estado;
    estado_t          proximo;
    logic [4:0]       msg_buf [MSG_LEN];
    logic [IDX_W-1:0] idx;
    // Scroll position kept as (symbol, column-within-symbol) so the window
    // lookup never needs a divide by 6; stream position = 6*pos_simb + pos_sub.
    logic [IDX_W-1:0] pos_simb;
    logic [2:0]       pos_sub;
    logic [PRE_W-1:0] prescaler;
    logic             transfer;
    logic [6:0]       janela [5];
    logic [3:0]       win_sub;
    logic [IDX_W-1:0] win_simb;

    // Column `sub` of the glyph for `code`; sub 5 is the spacer column.
    function automatic logic [6:0] glyph_col(input logic [4:0] code, input logic [2:0] sub);
        logic [34:0] g;
        case (code)
            5'd0:    g = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            5'd1:    g = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
            5'd2:    g = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
            5'd3:    g = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
            5'd4:    g = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
            5'd5:    g = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
            5'd6:    g = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
            5'd7:    g = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
            5'd8:    g = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            5'd9:    g = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
            5'd10:   g = {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
            5'd11:   g = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
            5'd12:   g = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
            5'd13:   g = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
            5'd14:   g = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
            5'd15:   g = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h01};
            default: g = '0;
        endcase
        case (sub)
            3'd0:    return g[34:28];
            3'd1:    return g[27:21];
            3'd2:    return g[20:14];
            3'd3:    return g[13:7];
            3'd4:    return g[6:0];
            default: return 7'h00;
        endcase
    endfunction

    // A new carregar pulse pre-empts any symbol offered in the same cycle.
    assign simb_ready = (estado == CARGA) && !carregar;
    assign ocupado    = (estado == CARGA);
    assign transfer   = simb_valid && simb_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= VAZIO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        if (carregar) begin
            proximo = CARGA;
        end else begin
            case (estado)
                CARGA:   if (transfer && idx == ULTIMO_IDX) proximo = EXIBE;
                default: proximo = estado;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            pos_simb  <= '0;
            pos_sub   <= '0;
            prescaler <= '0;
            for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= 5'd16;
        end else if (carregar) begin
            idx       <= '0;
            pos_simb  <= '0;
            pos_sub   <= '0;
            prescaler <= '0;
        end else if (transfer) begin
            msg_buf[idx] <= simb_code;
            if (idx == ULTIMO_IDX) begin
                idx       <= '0;
                pos_simb  <= '0;
                pos_sub   <= '0;
                prescaler <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if (estado == EXIBE && habilita) begin
            if (prescaler == PRE_FIM) begin
                prescaler <= '0;
                if (pos_sub == 3'd5) begin
                    pos_sub  <= '0;
                    pos_simb <= (pos_simb == ULTIMO_IDX) ? '0 : pos_simb + 1'b1;
                end else begin
                    pos_sub <= pos_sub + 1'b1;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Window column k sits k columns after the scroll position. With k <= 4
    // and pos_sub <= 5 at most one symbol boundary is crossed, so a single
    // conditional carry (wrapping past the last symbol) is enough.
    always_comb begin
        win_sub  = '0;
        win_simb = '0;
        for (int k = 0; k < 5; k++) begin
            win_sub  = {1'b0, pos_sub} + 4'(k);
            win_simb = pos_simb;
            if (win_sub >= 4'd6) begin
                win_sub  = win_sub - 4'd6;
                win_simb = (pos_simb == ULTIMO_IDX) ? '0 : pos_simb + 1'b1;
            end
            janela[k] = glyph_col(msg_buf[win_simb], win_sub[2:0]);
        end
    end

    // XOR with BLANK turns the active-high pattern active-low when inverted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coluna1 <= BLANK;
            coluna2 <= BLANK;
            coluna3 <= BLANK;
            coluna4 <= BLANK;
            coluna5 <= BLANK;
        end else if (estado == EXIBE) begin
            coluna1 <= janela[0] ^ BLANK;
            coluna2 <= janela[1] ^ BLANK;
            coluna3 <= janela[2] ^ BLANK;
            coluna4 <= janela[3] ^ BLANK;
            coluna5 <= janela[4] ^ BLANK;
        end else begin
            coluna1 <= BLANK;
            coluna2 <= BLANK;
            coluna3 <= BLANK;
            coluna4 <= BLANK;
            coluna5 <= BLANK;
        end
    end

endmodule
